sd_sequence_detector: RTL and testbench
=======================================

# sd_sequence_detector

Serial bit-stream sequence detector (top module `sd_sequence_detector`). Consumes one input bit per clock for a fixed-length frame and raises a Mealy-style match flag in the same cycle the final pattern bit is presented. Asserts a sticky completion flag once the whole frame has been consumed. Sits directly behind a serial stimulus source; results are sampled one bit per cycle by downstream capture logic.

## Interface
- `PATTERN`, default `4'b1011`: bit sequence to detect, MSB first (oldest bit).
- `PAT_LEN`, default 4: pattern length in bits, 2..8.
- `FRAME_LEN`, default 14: number of input bits per frame, 1..255.
- `clk  input  1`: single clock; all state updates on the rising edge.
- `rst  input  1`: reset, synchronous and active-high.
- `pattern_in  input  1`: serial data bit, one per cycle.
- `Dout  output  1`: combinational match flag for the current cycle.
- `done  output  1`: registered, sticky frame-complete flag.

## Operation
- Control FSM states:
  - RUN (reset state): bits accepted.
  - DONE: frame finished.
- Bit counter `cnt`, 8 bits, reset 0. It increments at each rising edge in RUN.
- Transition: RUN→DONE on the edge where `cnt == FRAME_LEN-1`. DONE holds until `rst`.
- History: `hist`, PAT_LEN-1 bits of previously accepted bits, plus `hvalid`, a count of valid history bits saturating at PAT_LEN-1. Both reset to 0.
- Match: `Dout = (state==RUN) && !rst && hvalid==PAT_LEN-1 && {hist, pattern_in}==PATTERN`.
  - Purely combinational from registered state and `pattern_in`.
- History update each edge in RUN: shift `pattern_in` into the LSB of `hist`, then `hvalid++` (saturating).
- Overlap handling after a match is set by the configuration macro (see Configuration).
- DONE: `pattern_in` ignored, `Dout` = 0, history frozen.
- `done` = (state==DONE), driven from a register.

## Timing
- Reset values: `done` = 0, `Dout` = 0, `cnt` = 0, `hist` = 0, `hvalid` = 0, state = RUN.
- Frame timing:
  - Bit k (k = 0 … FRAME_LEN-1) is the value on `pattern_in` during the k-th cycle after reset release.
  - `Dout` for bit k is valid in that same cycle, with zero latency.
- `done` rises at the rising edge that ends cycle FRAME_LEN-1, i.e. 14 edges after reset release by default. It stays high until `rst`.
- Reset mid-frame clears everything on the next edge. `Dout` is forced low combinationally while `rst` is high.
- Counter and history never wrap: `cnt` stops at FRAME_LEN-1 and the FSM leaves RUN.
- A match on the last frame bit is reported in cycle FRAME_LEN-1, before `done` rises.

## Configuration
- `SD_OVERLAP_EN` defined: overlapping detection. History shifts normally after a match, so the suffix of a match can begin the next match.
- `SD_OVERLAP_EN` undefined: non-overlapping detection. On an edge where `Dout`=1, `hist` and `hvalid` clear to 0, and the next match needs PAT_LEN fresh bits.

## Structure
- Package `sd_pkg` holds:
  - the FSM state enum `sd_state_t` {RUN, DONE};
  - default constants `SD_PATTERN`, `SD_PAT_LEN`, `SD_FRAME_LEN`;
  - counter width `SD_CNT_W` = 8.
- Sub-module `sd_bit_counter`:
  - frame counter with enable and sync reset;
  - outputs `last`, true when `cnt == FRAME_LEN-1`.
- The top module holds the FSM, the history register and the match logic.

## Test plan
- Overlap stream, `SD_OVERLAP_EN` defined.
  - Stimulus: reset, then bits 1,0,1,1,0,1,1,0,1,1,0,0,0,0.
  - Required: `Dout`=1 only in cycles 3, 6 and 9; `done` rises after 14 edges.
- Same stream, `SD_OVERLAP_EN` undefined.
  - Required: `Dout`=1 only in cycles 3 and 9.
- All-zero frame.
  - Required: `Dout` stays 0 for all 14 cycles; `done`=1 after the 14th edge and stays 1 for 10 further cycles while `pattern_in` toggles; `Dout` stays 0 throughout.
- Reset mid-frame.
  - Stimulus: bits 1,0,1, then `rst` high for one edge, then bit 1.
  - Required: `Dout`=0 on that bit, since history was cleared.
  - Continuing: `done` rises 14 edges after the second reset release.
- Match on final bit.
  - Stimulus: ten 0s, then 1,0,1,1.
  - Required: `Dout`=1 in cycle 13; `done` rises on the following edge.
- Reset values.
  - Stimulus: `rst` held high for 3 edges with `pattern_in`=1.
  - Required: `Dout`=0 and `done`=0 throughout.

Source files
------------

// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared types and default constants for the serial sequence detector
package sd_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } sd_state_t;

  localparam int         SD_CNT_W     = 8;
  localparam logic [3:0] SD_PATTERN   = 4'b1011;
  localparam int         SD_PAT_LEN   = 4;
  localparam int         SD_FRAME_LEN = 14;

endpackage

// File: rtl/sd_bit_counter.sv
// rtl/sd_bit_counter.sv - frame bit counter that parks on the last bit index
module sd_bit_counter
  import sd_pkg::*;
#(
  parameter int FRAME_LEN = SD_FRAME_LEN
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic last
);

  localparam logic [SD_CNT_W-1:0] CNT_LAST = SD_CNT_W'(FRAME_LEN - 1);

  logic [SD_CNT_W-1:0] cnt_q;
  logic [SD_CNT_W-1:0] cnt_d;

  assign last = (cnt_q == CNT_LAST);

  // Holding at the last index means the count can never wrap back into a live frame.
  always_comb begin
    cnt_d = cnt_q;
    if (en && !last) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sd_sequence_detector.sv
// rtl/sd_sequence_detector.sv - Mealy serial pattern detector over one fixed-length frame
// SD_OVERLAP_EN selects overlapping detection; undefined clears history after each match.
module sd_sequence_detector
  import sd_pkg::*;
#(
  parameter int               PAT_LEN   = SD_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = SD_PATTERN,
  parameter int               FRAME_LEN = SD_FRAME_LEN
) (
  input  logic clk,
  input  logic rst,
  input  logic pattern_in,
  output logic Dout,
  output logic done
);

  localparam int               HV_W   = $clog2(PAT_LEN);
  localparam logic [HV_W-1:0]  HV_MAX = HV_W'(PAT_LEN - 1);

  sd_state_t          state_q, state_d;
  logic [PAT_LEN-2:0] hist_q, hist_d;
  logic [HV_W-1:0]    hvalid_q, hvalid_d;
  logic [PAT_LEN-1:0] window;
  logic               match;
  logic               last;
  logic               cnt_en;

  assign cnt_en = (state_q == RUN);

  sd_bit_counter #(
    .FRAME_LEN(FRAME_LEN)
  ) u_bit_counter (
    .clk (clk),
    .rst (rst),
    .en  (cnt_en),
    .last(last)
  );

  always_comb begin
    state_d  = state_q;
    hist_d   = hist_q;
    hvalid_d = hvalid_q;
    window   = {hist_q, pattern_in};
    // rst gates the flag so a held reset never reports stale history.
    match    = (state_q == RUN) && !rst && (hvalid_q == HV_MAX) && (window == PATTERN);

    if (state_q == RUN) begin
      hist_d = window[PAT_LEN-2:0];
      if (hvalid_q != HV_MAX) begin
        hvalid_d = hvalid_q + 1'b1;
      end
`ifdef SD_OVERLAP_EN
`else
      if (match) begin
        hist_d   = '0;
        hvalid_d = '0;
      end
`endif
      if (last) begin
        state_d = DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      hist_q   <= '0;
      hvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      hist_q   <= hist_d;
      hvalid_q <= hvalid_d;
    end
  end

  assign Dout = match;
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_sd_sequence_detector.sv
// tb/tb_sd_sequence_detector.sv - directed self-checking bench for sd_sequence_detector
module tb_sd_sequence_detector;

  logic clk;
  logic rst;
  logic pattern_in;
  logic Dout;
  logic done;

  int checks   = 0;
  int failures = 0;

  sd_sequence_detector dut (
    .clk       (clk),
    .rst       (rst),
    .pattern_in(pattern_in),
    .Dout      (Dout),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One reset edge; pattern_in=1 so an ungated match would show up here.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst        = 1'b1;
    pattern_in = 1'b1;
    #1;
    chk({tag, "_rst_dout"}, Dout, 1'b0);
  endtask

  // Releases reset, plays a full frame and checks Dout per cycle and done afterwards.
  task automatic run_frame(input string tag, input logic [0:13] bits, input logic [0:13] exp);
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      rst        = 1'b0;
      pattern_in = bits[k];
      #1;
      chk($sformatf("%s_dout_c%0d", tag, k), Dout, exp[k]);
      chk($sformatf("%s_done_c%0d", tag, k), done, 1'b0);
    end
    @(negedge clk);
    pattern_in = 1'b0;
    #1;
    chk({tag, "_done_after"}, done, 1'b1);
    chk({tag, "_dout_after"}, Dout, 1'b0);
  endtask

  logic [0:13] stream_bits;
  logic [0:13] stream_exp;

  initial begin
    rst        = 1'b1;
    pattern_in = 1'b0;

    // Reset held for three edges with pattern_in=1.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rst        = 1'b1;
      pattern_in = 1'b1;
      #1;
      chk($sformatf("reset_dout_%0d", i), Dout, 1'b0);
      chk($sformatf("reset_done_%0d", i), done, 1'b0);
    end

    // Mixed stream with three candidate matches.
    stream_bits = 14'b10110110110000;
`ifdef SD_OVERLAP_EN
    stream_exp  = 14'b00010010010000;
`else
    stream_exp  = 14'b00010000010000;
`endif
    do_reset("stream");
    run_frame("stream", stream_bits, stream_exp);

    // All-zero frame, then DONE must ignore toggling input.
    do_reset("zero");
    run_frame("zero", 14'b00000000000000, 14'b00000000000000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      pattern_in = i[0];
      #1;
      chk($sformatf("zero_hold_done_%0d", i), done, 1'b1);
      chk($sformatf("zero_hold_dout_%0d", i), Dout, 1'b0);
    end

    // Reset mid-frame after 1,0,1; the next 1 must not match.
    do_reset("mid");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      rst        = 1'b0;
      pattern_in = (k != 1);
      #1;
      chk($sformatf("mid_pre_dout_c%0d", k), Dout, 1'b0);
    end
    do_reset("mid2");
    run_frame("mid_post", 14'b10110000000000, 14'b00010000000000);

    // Match on the final frame bit.
    do_reset("final");
    run_frame("final", 14'b00000000001011, 14'b00000000000001);

    // Reset out of DONE returns to RUN.
    do_reset("redo");
    @(negedge clk);
    #1;
    chk("redo_done_cleared", done, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
